// File: rtl/decoder_grant_arbiter_if.sv
// Request/grant bundle between four requesters and the decoder grant arbiter.
// master: requester side drives req; slave: arbiter drives decoder select and status.
interface decoder_grant_arbiter_if;
    logic [3:0] req;
    logic       a;
    logic       b;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  a, b, gnt, gnt_vld, busy, timeout
    );

    modport slave (
        input  req,
        output a, b, gnt, gnt_vld, busy, timeout
    );
endinterface

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter sharing a 2-to-4 decoder (select {a,b}) among four requesters; 1-cycle grant latency.
// Grant held until release (or hold limit when DECODER_ARB_TIMEOUT_EN is defined), then a 1-cycle GAP.
module decoder_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_grant_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic [1:0] last, last_nx;
    logic [3:0] gnt, gnt_nx;
    logic       vld, vld_nx;
    logic       tmo, tmo_nx;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       hold_hit;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

`ifdef DECODER_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt, hold_nx;

    // Limit is checked before increment, so hold_cnt never reaches MAX_HOLD.
    assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_nx;
    end
`else
    assign hold_hit = 1'b0;
`endif

    // Scan last+1 .. last+4 (mod 4); the final step revisits last itself.
    always_comb begin
        winner = last;
        cand   = last;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + k[1:0];
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        last_nx  = last;
        gnt_nx   = gnt;
        vld_nx   = vld;
        tmo_nx   = 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
        hold_nx  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    idx_nx   = winner;
                    gnt_nx   = 4'b0001 << winner;
                    vld_nx   = 1'b1;
`ifdef DECODER_ARB_TIMEOUT_EN
                    hold_nx  = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[idx]) begin
                    state_nx = GAP;
                    vld_nx   = 1'b0;
                    gnt_nx   = 4'b0000;
                    last_nx  = idx;
                end else if (hold_hit) begin
                    state_nx = GAP;
                    vld_nx   = 1'b0;
                    gnt_nx   = 4'b0000;
                    last_nx  = idx;
                    tmo_nx   = 1'b1;
                end else begin
`ifdef DECODER_ARB_TIMEOUT_EN
                    hold_nx  = hold_cnt + 1'b1;
`endif
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            last  <= 2'd3;
            gnt   <= 4'b0000;
            vld   <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            last  <= last_nx;
            gnt   <= gnt_nx;
            vld   <= vld_nx;
            tmo   <= tmo_nx;
        end
    end

    assign bus.a       = idx[1];
    assign bus.b       = idx[0];
    assign bus.gnt     = gnt;
    assign bus.gnt_vld = vld;
    assign bus.busy    = (state != IDLE);
    assign bus.timeout = tmo;
endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter and sequencer that shares the 2-to-4 decoder between four requesters. It samples four request lines, picks a winner, and drives the decoder select inputs `a`/`b`. It holds the grant until the winner releases or a hold limit expires, then inserts a one-cycle gap before the next arbitration. The decoder's `y0..y3` outputs become the one-hot select lines for the shared resource; consumers qualify them with `gnt_vld`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may stay valid. Legal range 1..255.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request vector; `req[i]` high = requester i wants the decoder.
- `a`  out  1  decoder select MSB = granted index bit 1.
- `b`  out  1  decoder select LSB = granted index bit 0.
- `gnt`  out  4  registered one-hot grant, equal to `1 << {a,b}` while `gnt_vld`, else 0.
- `gnt_vld`  out  1  high while a grant is active.
- `busy`  out  1  high in any state except IDLE.
- `timeout`  out  1  one-cycle pulse when a grant is terminated by the hold limit.

## Operation
- States: IDLE, GRANT, GAP. Reset enters IDLE.
- Reset values: `a`=0, `b`=0, `gnt`=0, `gnt_vld`=0, `busy`=0, `timeout`=0. Internal `last`=3, `hold_cnt`=0.
- IDLE:
  - With `req`==0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning `last+1, last+2, ...` mod 4.
  - Go to GRANT. Load `{a,b}` = winner, set `gnt` one-hot, `gnt_vld`=1, `hold_cnt`=0.
- GRANT: evaluate in this order at each edge.
  1. Release: `req[{a,b}]`==0. Go to GAP; `timeout` stays 0.
  2. Hold limit (only if `TIMEOUT_EN` is defined): `hold_cnt`==`MAX_HOLD`-1. Go to GAP and set `timeout`=1.
  3. Otherwise stay in GRANT and increment `hold_cnt`.
  - On entry to GAP: `gnt_vld`=0, `gnt`=0, `last`={a,b}.
- GAP: unconditionally go to IDLE next edge and clear `timeout`.
- `a`/`b` hold the last granted index outside GRANT. The decoder has no enable, so `y*` stay one-hot; only `gnt`/`gnt_vld` indicate ownership.
- Requests that appear or drop for non-granted indices during GRANT/GAP have no effect until the next IDLE evaluation.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`; it never wraps, since the limit is checked before increment.

## Timing
- Request to grant: `req` sampled in IDLE at edge k gives `gnt_vld`=1 after edge k (1-cycle latency).
- Grant duration: `gnt_vld` is high for N cycles if the winner's `req` is first seen low at the N-th edge after grant. The maximum is `MAX_HOLD` cycles.
- Re-arbitration spacing: grant end at edge e gives GAP for the cycle after e, IDLE after e+1, and the earliest next grant after edge e+2. Minimum 2 idle cycles between grants.
- `timeout` is high exactly for the GAP cycle.
- Reset in any state returns all outputs to reset values on the next edge. A grant in progress is dropped without a `timeout` pulse, and `last` returns to 3.
- Release and hold limit reached at the same edge: treated as release, no `timeout`.

## Configuration
- `DECODER_ARB_TIMEOUT_EN` (referred to above as `TIMEOUT_EN`).
  - Defined: the hold limit is enforced as above.
  - Undefined: `hold_cnt` and the limit check are removed, and a grant lasts until release. `timeout` is tied to 0 and `MAX_HOLD` is ignored.

## Test plan
- Reset: assert `rst` 2 cycles with `req`=4'b1111. Expect `gnt_vld`=0, `a`=`b`=0, `gnt`=0, `busy`=0, `timeout`=0. First grant after release of `rst` is index 0.
- Single request: `req`=4'b0100 for 3 cycles, then 0. Expect `a`=1, `b`=0, `gnt`=4'b0100 one cycle after sampling, valid 3 cycles. Then GAP, then IDLE with `busy`=0.
- Round-robin saturation (macro on, `MAX_HOLD`=8): `req`=4'b1111 held. Expect grants 0,1,2,3,0,...:
  - each grant valid exactly 8 cycles;
  - `timeout` pulses once per grant;
  - 2-cycle gap between grants.
- Release/limit collision: `req`=4'b0010, dropped at the edge where `hold_cnt`=7. Expect grant ends and `timeout` stays 0. The next grant goes to index 2 if `req[2]` is set, not index 1.
- Reset mid-grant: assert `rst` on the 4th cycle of a grant to index 3. All outputs return to 0 next cycle. The next grant with `req`=4'b1001 goes to index 0.
- Macro off: `req`=4'b0001 held 50 cycles. `gnt_vld` stays high all 50 cycles and `timeout` is never asserted.
